// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO stack controller in front of a single-port synchronous memory.
//
// Optional feature macro: STACK_CTRL_ERR_EN
//   defined   -> o_err pulses with o_done when an illegal request completes
//   undefined -> o_err tied low; illegal requests still complete silently
//
// Ports
//   i_clock       clock, all state changes on the rising edge
//   i_reset_n     asynchronous active-low reset
//   i_req_valid   request presented
//   i_req_op      00 push, 01 pop, 10 peek, 11 clear
//   i_req_data    push operand
//   o_req_ready   high only while idle
//   o_done        one-cycle completion pulse
//   o_rdata       pop/peek result, held until the next pop/peek completes
//   o_mem_addr    memory address
//   o_mem_wdata   memory write data
//   o_mem_w       memory write enable
//   o_mem_s       memory read select (read data returns one cycle later)
//   i_mem_rdata   memory read data
//   o_count       occupancy, also the next free slot
//   o_full        o_count == 2^ADDR_W
//   o_empty       o_count == 0
//   o_err         illegal-operation pulse, coincident with o_done
module stack_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  input  logic [1:0]        i_req_op,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_req_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_w,
  output logic              o_mem_s,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_err
);

  localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic [1:0] OpPush  = 2'b00;
  localparam logic [1:0] OpPop   = 2'b01;
  localparam logic [1:0] OpPeek  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPopDec,
    StPopRd,
    StPopCap,
    StDoneErr
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W:0]   count_m1;

  assign count_m1    = count_q - CntOne;
  assign o_count     = count_q;
  assign o_full      = (count_q == Depth);
  assign o_empty     = (count_q == '0);
  assign o_rdata     = rdata_q;
  assign o_req_ready = (state_q == StIdle);

  // Clear also completes through StDoneErr; op_q tells it apart from a real error.
`ifdef STACK_CTRL_ERR_EN
  assign o_err = (state_q == StDoneErr) && (op_q != OpClear);
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= OpPush;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    o_done      = 1'b0;
    o_mem_w     = 1'b0;
    o_mem_s     = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          op_d   = i_req_op;
          data_d = i_req_data;
          case (i_req_op)
            OpPush:        state_d = o_full ? StDoneErr : StPush;
            OpPop, OpPeek: state_d = o_empty ? StDoneErr : StPopDec;
            default: begin
              // Clear takes effect at acceptance; completion is signalled next cycle.
              count_d = '0;
              state_d = StDoneErr;
            end
          endcase
        end
      end

      StPush: begin
        o_mem_w     = 1'b1;
        o_mem_addr  = count_q[ADDR_W-1:0];
        o_mem_wdata = data_q;
        o_done      = 1'b1;
        count_d     = count_q + CntOne;
        state_d     = StIdle;
      end

      StPopDec: begin
        if (op_q == OpPop) begin
          count_d = count_m1;
        end
        state_d = StPopRd;
      end

      StPopRd: begin
        // Pop already decremented, so count is the top; peek must look one below.
        o_mem_s    = 1'b1;
        o_mem_addr = (op_q == OpPop) ? count_q[ADDR_W-1:0] : count_m1[ADDR_W-1:0];
        state_d    = StPopCap;
      end

      StPopCap: begin
        o_done  = 1'b1;
        rdata_d = i_mem_rdata;
        state_d = StIdle;
      end

      StDoneErr: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, width of the memory address; stack depth DEPTH = 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 16, width of the data word.
REQ-003 Port i_clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port i_reset_n  in  1  reset; asynchronous, active-low.
REQ-005 Port i_req_valid  in  1  request presented.
REQ-006 Port i_req_op  in  2  operation: 00 push, 01 pop, 10 peek, 11 clear.
REQ-007 Port i_req_data  in  DATA_W  push operand.
REQ-008 Port o_req_ready  out  1  controller can accept a request.
REQ-009 Port o_done  out  1  one-cycle completion pulse.
REQ-010 Port o_rdata  out  DATA_W  pop/peek result, held until the next pop/peek completes.
REQ-011 Port o_mem_addr  out  ADDR_W  memory address.
REQ-012 Port o_mem_wdata  out  DATA_W  memory write data.
REQ-013 Port o_mem_w  out  1  memory write enable.
REQ-014 Port o_mem_s  out  1  memory read select (memory drives read data).
REQ-015 Port i_mem_rdata  in  DATA_W  memory read data, valid one cycle after o_mem_s.
REQ-016 Port o_count  out  ADDR_W+1  current occupancy (stack pointer, next free slot).
REQ-017 Port o_full / o_empty  out  1 each  o_count==DEPTH / o_count==0, combinational from o_count.
REQ-018 Port o_err  out  1  illegal-operation pulse, coincident with o_done.

Function
REQ-019 States SHALL be IDLE, PUSH, POP_DEC, POP_RD, POP_CAP, DONE_ERR; o_req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a rising edge with i_req_valid and o_req_ready both 1; op and data registered on acceptance.
REQ-021 Push: IDLE->PUSH; in PUSH o_mem_w=1, o_mem_addr=count[ADDR_W-1:0], o_mem_wdata=registered data; on exit count<=count+1, o_done=1 in that PUSH cycle; back to IDLE.
REQ-022 Pop: IDLE->POP_DEC (count<=count-1) ->POP_RD (o_mem_s=1, o_mem_addr=count) ->POP_CAP (o_rdata<=i_mem_rdata, o_done=1) ->IDLE.
REQ-023 Peek: as pop but POP_DEC SHALL NOT modify count; POP_RD addresses count-1.
REQ-024 Clear: count<=0 and o_done=1 in the cycle after acceptance; memory untouched.
REQ-025 Latency acceptance-edge to o_done: push 1 cycle, clear 1 cycle, pop/peek 3 cycles.
REQ-026 o_mem_w and o_mem_s SHALL never be 1 simultaneously and SHALL be 0 in IDLE and DONE_ERR.
REQ-027 Push when o_full, or pop/peek when o_empty, SHALL go to DONE_ERR: no memory access, count unchanged, o_done=1 one cycle after acceptance, then IDLE.
REQ-028 Back-to-back requests SHALL be accepted in the first IDLE cycle after o_done; i_req_valid outside IDLE is ignored.

Reset
REQ-029 Assertion of i_reset_n low SHALL immediately force IDLE, count=0, o_rdata=0, o_done=0, o_err=0, o_mem_w=0, o_mem_s=0, aborting any in-flight operation; memory contents are not cleared.
REQ-030 First request SHALL be acceptable on the first rising edge after i_reset_n deasserts.

Configuration
REQ-031 Macro STACK_CTRL_ERR_EN defined: o_err pulses 1 with o_done for each DONE_ERR completion.
REQ-032 Macro STACK_CTRL_ERR_EN undefined: o_err tied 0; illegal requests still take the DONE_ERR path silently.

Verification
REQ-033 Reset, push 0x1234, 0xABCD -> o_mem_w at addr 0 then 1, o_count=2, o_done 1 cycle after each acceptance.
REQ-034 Then pop -> o_rdata=0xABCD 3 cycles after acceptance, o_count=1; peek -> o_rdata=0x1234, o_count stays 1.
REQ-035 From reset, pop -> no o_mem_s, o_count=0, o_done and (with STACK_CTRL_ERR_EN) o_err high 1 cycle after acceptance.
REQ-036 ADDR_W=2: push 4 words -> o_full=1; 5th push -> o_err=1, addr 0 contents unchanged on subsequent pops (pops return 4th..1st in order).
REQ-037 Push 3 words, clear -> o_count=0, o_empty=1 one cycle after acceptance.
REQ-038 Assert i_reset_n low during POP_RD -> o_mem_s=0 and count=0 without waiting for a clock edge; o_done never pulses for the aborted pop.
